// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of RUN cycles needed to retire an m-bit multiplier r bits at a time.
  function automatic int num_steps(input int m, input int r);
    return m / r;
  endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One combinational radix-2^R step: acc + mcand * digit, where the top digit
// bit carries negative weight when the final digit of a signed multiplier is used.
module mult_pp_step #(
  parameter int W = 64,
  parameter int R = 1
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] mcand,
  input  logic [R-1:0] digit,
  input  logic         neg_msb,
  output logic [W-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < R; i++) begin
      if (digit[i]) begin
        // Two's-complement sign bit of the multiplier weighs -2^(M-1).
        if (neg_msb && (i == R - 1))
          acc_next = acc_next - (mcand << i);
        else
          acc_next = acc_next + (mcand << i);
      end
    end
  end

endmodule

// File: rtl/mult_iter.sv
// Iterative N x M multiplier retiring R multiplier bits per cycle, signed or
// unsigned, with valid/ready handshakes on both sides.
module mult_iter
  import mult_pkg::*;
#(
  parameter int N = 32,
  parameter int M = N,
  parameter int R = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [M-1:0]   X,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] AX,
  output logic           busy
);

  localparam int W  = N + M;
  localparam int L  = num_steps(M, R);
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  if ((R < 1) || (R > M) || ((M % R) != 0)) begin : g_bad_r
    $error("mult_iter: R must divide M");
  end

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   mcand;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_nx;
  logic [M-1:0]   mplier;
  logic           sgn;
  logic           last;

  assign last = (cnt == CW'(L - 1));

  // The multiplicand is pre-extended to full product width and shifted left
  // each step, so the step adder never needs a variable shifter.
  mult_pp_step #(.W(W), .R(R)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .digit    (mplier[R-1:0]),
    .neg_msb  (sgn & last),
    .acc_next (acc_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last)     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      sgn    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cnt    <= '0;
          acc    <= '0;
          mcand  <= {{M{is_signed & A[N-1]}}, A};
          mplier <= X;
          sgn    <= is_signed;
        end
        RUN: begin
          acc    <= acc_nx;
          mcand  <= mcand << R;
          mplier <= mplier >> R;
          cnt    <= last ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign AX        = acc;

endmodule
